// File: rtl/set_bit_enumerator_pkg.sv
// Shared ALU definitions for the set-bit enumerator: state encoding,
// datapath widths and the popcount helper.
package set_bit_enumerator_pkg;

    localparam int OPERAND_W = 8;
    localparam int INDEX_W   = 3;
    localparam int COUNT_W   = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Count width is one bit wider than an index so that 8 is representable
    function automatic logic [COUNT_W-1:0] popcount(input logic [OPERAND_W-1:0] v);
        logic [COUNT_W-1:0] c;
        c = 4'd0;
        for (int i = 0; i < OPERAND_W; i++) begin
            c = c + COUNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/set_bit_enumerator_if.sv
// Operand-in / index-out handshake bundle of the set-bit enumerator.
interface set_bit_enumerator_if;
    import set_bit_enumerator_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [OPERAND_W-1:0] in_operand;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [INDEX_W-1:0]   out_index;
    logic [COUNT_W-1:0]   out_seq;
    logic [COUNT_W-1:0]   out_total;
    logic                 out_last;
    logic                 out_zero;

    modport master (
        output in_valid, in_operand, flush, out_ready,
        input  in_ready, out_valid, out_index, out_seq, out_total, out_last, out_zero
    );

    modport slave (
        input  in_valid, in_operand, flush, out_ready,
        output in_ready, out_valid, out_index, out_seq, out_total, out_last, out_zero
    );
endinterface

// File: rtl/set_bit_enumerator_fsb.sv
// FirstSetBit scanner: low nibble = lowest set index, high nibble = highest
// set index, both 0 for a zero operand.
module set_bit_enumerator_fsb
    import set_bit_enumerator_pkg::*;
(
    input  logic [OPERAND_W-1:0] operand,
    output logic [7:0]           code
);

    logic [INDEX_W-1:0] lo_s;
    logic [INDEX_W-1:0] hi_s;

    // Priority scans from opposite ends; the last hit in each loop wins
    always_comb begin
        lo_s = 3'd0;
        hi_s = 3'd0;
        for (int i = OPERAND_W - 1; i >= 0; i--) begin
            lo_s = operand[i] ? INDEX_W'(i) : lo_s;
        end
        for (int i = 0; i < OPERAND_W; i++) begin
            hi_s = operand[i] ? INDEX_W'(i) : hi_s;
        end
    end

    assign code = {1'b0, hi_s, 1'b0, lo_s};

endmodule

// File: rtl/set_bit_enumerator.sv
// Enumerates the set bits of an accepted operand, one index per beat,
// ascending (DESCEND=0) or descending (DESCEND=1).
module set_bit_enumerator
    import set_bit_enumerator_pkg::*;
#(
    parameter bit DESCEND = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    set_bit_enumerator_if.slave  bus
);

    state_t               state_r, state_s;
    logic [OPERAND_W-1:0] work_r, work_s;
    logic [COUNT_W-1:0]   seq_r, seq_s;
    logic [COUNT_W-1:0]   total_r, total_s;
    logic                 in_ready_r;

    logic [7:0]           code_s;
    logic [3:0]           nib_s;
    logic                 nib_unused_s;
    logic [INDEX_W-1:0]   idx_s;
    logic                 emit_s;
    logic                 last_s;
    logic                 accept_s;
    logic                 xfer_s;

    set_bit_enumerator_fsb u_fsb (
        .operand (work_r),
        .code    (code_s)
    );

    assign nib_s        = DESCEND ? code_s[7:4] : code_s[3:0];
    assign nib_unused_s = nib_s[3];
    assign idx_s        = nib_s[2:0];

    assign emit_s   = (state_r == EMIT);
    // At most one bit left (including none) means this beat closes the transaction
    assign last_s   = ((work_r & (work_r - 8'd1)) == 8'd0);
    assign accept_s = (state_r == IDLE) && in_ready_r && bus.in_valid;
    assign xfer_s   = emit_s && bus.out_ready;

    // Next-state and datapath update; flush overrides everything
    always_comb begin
        state_s = state_r;
        work_s  = work_r;
        seq_s   = seq_r;
        total_s = total_r;
        if (bus.flush) begin
            state_s = IDLE;
            work_s  = 8'd0;
            seq_s   = 4'd0;
            total_s = 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_s = EMIT;
                        work_s  = bus.in_operand;
                        seq_s   = 4'd0;
                        total_s = popcount(bus.in_operand);
                    end else begin
                        state_s = IDLE;
                    end
                end
                EMIT: begin
                    if (xfer_s) begin
                        work_s  = work_r & ~(8'd1 << idx_s);
                        seq_s   = seq_r + 4'd1;
                        state_s = last_s ? IDLE : EMIT;
                    end else begin
                        state_s = EMIT;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State, work, counters and the ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            work_r     <= 8'd0;
            seq_r      <= 4'd0;
            total_r    <= 4'd0;
            in_ready_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            work_r     <= work_s;
            seq_r      <= seq_s;
            total_r    <= total_s;
            in_ready_r <= (state_s == IDLE);
        end
    end

    // Beat outputs are forced to 0 outside EMIT so reset and IDLE read all-zero
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_index = 3'd0;
        bus.out_seq   = 4'd0;
        bus.out_total = 4'd0;
        bus.out_last  = 1'b0;
        bus.out_zero  = 1'b0;
        if (emit_s) begin
            bus.out_valid = 1'b1;
            bus.out_index = idx_s;
            bus.out_seq   = seq_r;
            bus.out_total = total_r;
            bus.out_last  = last_s;
            bus.out_zero  = (work_r == 8'd0);
        end else begin
            bus.out_valid = 1'b0;
        end
    end

    assign bus.in_ready = in_ready_r;

endmodule

// File: tb/tb_set_bit_enumerator.sv
// Directed bench driving an ascending and a descending enumerator in lockstep.
module tb_set_bit_enumerator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_operand = 8'd0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b1;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    set_bit_enumerator_if if0 ();
    set_bit_enumerator_if if1 ();

    assign if0.in_valid   = in_valid;
    assign if0.in_operand = in_operand;
    assign if0.flush      = flush;
    assign if0.out_ready  = out_ready;
    assign if1.in_valid   = in_valid;
    assign if1.in_operand = in_operand;
    assign if1.flush      = flush;
    assign if1.out_ready  = out_ready;

    set_bit_enumerator #(.DESCEND(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    set_bit_enumerator #(.DESCEND(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat0(input string tag, input int idx, input int seq, input int tot,
                         input bit last, input bit zero);
        chk({tag, "_d0_valid"}, 16'(if0.out_valid), 16'd1);
        chk({tag, "_d0_index"}, 16'(if0.out_index), 16'(idx));
        chk({tag, "_d0_seq"},   16'(if0.out_seq),   16'(seq));
        chk({tag, "_d0_total"}, 16'(if0.out_total), 16'(tot));
        chk({tag, "_d0_last"},  16'(if0.out_last),  16'(last));
        chk({tag, "_d0_zero"},  16'(if0.out_zero),  16'(zero));
        chk({tag, "_d0_ready"}, 16'(if0.in_ready),  16'd0);
    endtask

    task automatic beat1(input string tag, input int idx, input int seq, input int tot,
                         input bit last, input bit zero);
        chk({tag, "_d1_valid"}, 16'(if1.out_valid), 16'd1);
        chk({tag, "_d1_index"}, 16'(if1.out_index), 16'(idx));
        chk({tag, "_d1_seq"},   16'(if1.out_seq),   16'(seq));
        chk({tag, "_d1_total"}, 16'(if1.out_total), 16'(tot));
        chk({tag, "_d1_last"},  16'(if1.out_last),  16'(last));
        chk({tag, "_d1_zero"},  16'(if1.out_zero),  16'(zero));
    endtask

    task automatic idle(input string tag);
        chk({tag, "_d0_idle"}, {14'd0, if0.in_ready, if0.out_valid}, 16'b10);
        chk({tag, "_d1_idle"}, {14'd0, if1.in_ready, if1.out_valid}, 16'b10);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_d0_zero_outs"},
            {1'b0, if0.in_ready, if0.out_valid, if0.out_index, if0.out_seq,
             if0.out_total, if0.out_last, if0.out_zero}, 16'd0);
        chk({tag, "_d1_zero_outs"},
            {1'b0, if1.in_ready, if1.out_valid, if1.out_index, if1.out_seq,
             if1.out_total, if1.out_last, if1.out_zero}, 16'd0);
    endtask

    task automatic offer(input logic [7:0] op);
        in_operand = op;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
    endtask

    initial begin
        // Reset
        tick();
        all_zero("reset");
        rst_n = 1'b1;
        tick();
        idle("post_reset");

        // 8'hA4, continuous out_ready
        offer(8'hA4);
        beat0("a4_b0", 2, 0, 3, 1'b0, 1'b0);
        beat1("a4_b0", 7, 0, 3, 1'b0, 1'b0);
        tick();
        beat0("a4_b1", 5, 1, 3, 1'b0, 1'b0);
        beat1("a4_b1", 5, 1, 3, 1'b0, 1'b0);
        tick();
        beat0("a4_b2", 7, 2, 3, 1'b1, 1'b0);
        beat1("a4_b2", 2, 2, 3, 1'b1, 1'b0);
        tick();
        idle("a4_done");

        // Zero operand
        offer(8'h00);
        beat0("zero", 0, 0, 0, 1'b1, 1'b1);
        beat1("zero", 0, 0, 0, 1'b1, 1'b1);
        tick();
        idle("zero_done");

        // 8'hFF with two stall cycles before every transfer
        offer(8'hFF);
        for (int b = 0; b < 8; b++) begin
            beat0($sformatf("ff_b%0d", b), b, b, 8, (b == 7), 1'b0);
            beat1($sformatf("ff_b%0d", b), 7 - b, b, 8, (b == 7), 1'b0);
            out_ready = 1'b0;
            tick();
            beat0($sformatf("ff_s1_b%0d", b), b, b, 8, (b == 7), 1'b0);
            tick();
            beat0($sformatf("ff_s2_b%0d", b), b, b, 8, (b == 7), 1'b0);
            beat1($sformatf("ff_s2_b%0d", b), 7 - b, b, 8, (b == 7), 1'b0);
            out_ready = 1'b1;
            tick();
        end
        idle("ff_done");

        // 8'h81, flush on the second EMIT cycle
        offer(8'h81);
        beat0("f81_b0", 0, 0, 2, 1'b0, 1'b0);
        tick();
        beat0("f81_b1", 7, 1, 2, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle("f81_flushed");
        chk("f81_d0_total_cleared", 16'(if0.out_total), 16'd0);
        tick();
        idle("f81_quiet");

        // Flush in IDLE beats a simultaneous offer
        flush = 1'b1;
        offer(8'h0F);
        flush = 1'b0;
        idle("flush_idle");
        tick();
        idle("flush_idle_quiet");

        // Reset during the second beat of 8'h0E
        offer(8'h0E);
        beat0("r0e_b0", 1, 0, 3, 1'b0, 1'b0);
        tick();
        beat0("r0e_b1", 2, 1, 3, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        all_zero("midreset");
        tick();
        all_zero("midreset_hold");
        rst_n = 1'b1;
        tick();
        idle("midreset_release");
        offer(8'h10);
        beat0("r10", 4, 0, 1, 1'b1, 1'b0);
        beat1("r10", 4, 0, 1, 1'b1, 1'b0);
        tick();
        idle("r10_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/set_bit_enumerator.md
Name: set_bit_enumerator

Overview:
- Sequential stage directly downstream of the 8-bit FirstSetBit scanner.
- Accepts one 8-bit operand per transaction over a valid/ready handshake.
- Emits the index of every set bit, one index per beat, in ascending or descending order, with per-beat ordinal, total-count and last flags.
- Feeds the ALU result path with bit-position streams. Examples: bit-field extract and interrupt-priority service.

Parameters:
- DESCEND, 0, scan order: 0 = lowest set bit first (scanner low nibble); 1 = highest set bit first (scanner high nibble).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand offered
- in_ready  out  1  block can accept an operand
- in_operand  in  8  operand to enumerate
- flush  in  1  synchronous abort of the current transaction
- out_valid  out  1  index beat valid
- out_ready  in  1  consumer accepts beat
- out_index  out  3  bit position of the current beat
- out_seq  out  4  ordinal of the current beat, 0-based
- out_total  out  4  popcount of the accepted operand, 0..8
- out_last  out  1  final beat of the transaction
- out_zero  out  1  operand was 0; beat carries no index

Behaviour:
- Reset:
  - Async on rst_n low: state IDLE; work register, seq and total cleared to 0.
  - All outputs 0 while rst_n is low, including in_ready.
  - in_ready rises in the first cycle after rst_n deasserts.
- States: IDLE, EMIT.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid: latch in_operand into work, total = popcount(in_operand), seq = 0, then go to EMIT next cycle.
- EMIT:
  - in_ready = 0, out_valid = 1.
  - out_index comes from the scanner instance on work: low nibble if DESCEND = 0, high nibble if DESCEND = 1, truncated to 3 bits.
  - out_seq = seq, out_total = total.
  - out_zero = (work == 0).
  - out_last = out_zero, or work has exactly one bit set.
- Beat transfer (out_valid & out_ready):
  - Clear bit out_index in work and increment seq.
  - If out_last, return to IDLE.
- Latency and throughput:
  - Operand accepted at edge N; first beat is valid in cycle N+1.
  - One beat per cycle under continuous out_ready.
  - Transaction of k set bits lasts k beats; a zero operand yields exactly 1 beat.
  - After the last beat, IDLE holds for 1 cycle before the next accept. Max rate is one operand per k+1 cycles.
- Backpressure: while out_valid & !out_ready, every out_* signal holds stable.
- Zero operand: scanner output is ambiguous (0), so out_zero = 1, out_index = 0, out_last = 1, out_total = 0.
- Flush:
  - In any state, forces IDLE at the next edge and clears work, seq and total. Any beat presented in that cycle is discarded even if out_ready is high.
  - flush in IDLE with in_valid: flush wins, operand not accepted.
- Widths:
  - seq never exceeds 7 on a valid beat.
  - total is computed with 4-bit width so that 8 is representable.
- rst_n asserted mid-transaction: immediate return to the reset values above; no partial beat afterward.

Decomposition:
- Shared ALU package:
  - state enum (IDLE, EMIT)
  - constant OPERAND_W = 8
  - constant INDEX_W = 3
  - constant COUNT_W = 4
- One natural sub-module: instance of the existing FirstSetBit scanner on the work register. Its encoding is low nibble = lowest set index, high nibble = highest set index, both 0 for a zero operand.
- Popcount is an inline function, not a separate module.

Test Plan:
- DESCEND=0, operand 8'hA4, out_ready=1 -> beats index 2,5,7; seq 0,1,2; total 3; last only on index 7; first beat one cycle after accept.
- DESCEND=1, operand 8'hA4 -> beats index 7,5,2; last on 2.
- Operand 8'h00 -> single beat: zero=1, last=1, index 0, total 0; then IDLE with in_ready=1.
- Operand 8'hFF, out_ready toggled 1,0,0,1,... -> 8 beats 0..7 in order; outputs held stable on stall cycles; seq 7 with last on index 7; total 8.
- Operand 8'h81, flush pulsed on the second EMIT cycle -> only index 0 transferred; IDLE next cycle; no further beats.
- rst_n low during beat 2 of 8'h0E -> all outputs 0 immediately; in_ready=1 the cycle after release; next operand 8'h10 -> single beat index 4, last=1.
